// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write bus driven by the UART boot loader.
//   imem_we    : one-cycle write strobe
//   imem_addr  : word address of the write (ADDR_W bits)
//   imem_wdata : 32-bit instruction word, valid while imem_we = 1
// master = loader side, slave = instruction memory side.
interface imem_uart_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, imem_addr, imem_wdata);
  modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART boot loader: receives a program image over rx and writes it word by word
// into instruction memory while holding the CPU in reset.
// Image: 16-bit little-endian word count N, then N little-endian 32-bit words.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   rx       : UART line, idle high, 8 data bits LSB first, 1 stop bit
//   imem     : imem_uart_loader_if.master (imem_we / imem_addr / imem_wdata)
//   cpu_hold : 1 = keep CPU in reset until the image is loaded
//   done     : image fully loaded, sticky until reset
//   err      : sticky error (framing, parity, address overflow)
// Parameters: CLKS_PER_BIT (>= 8) clocks per UART bit; ADDR_W (<= 16) imem word-address width.
// Optional feature: define IMEM_LOADER_PARITY_EN for 8E1 frames (even parity bit after D7).
module imem_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  imem_uart_loader_if.master  imem,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef IMEM_LOADER_PARITY_EN
    RX_PAR,
`endif
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

  typedef enum logic [1:0] {
    LD_CNT_LO,
    LD_CNT_HI,
    LD_DATA,
    LD_DONE
  } ld_state_e;

  // rx synchronizer plus one history flop for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // UART receiver: start-edge resync, mid-bit sampling, one-cycle byte_valid
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             byte_valid_q;
  logic             rx_err_q;
`ifdef IMEM_LOADER_PARITY_EN
  logic             par_bad_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
`ifdef IMEM_LOADER_PARITY_EN
      par_bad_q    <= 1'b0;
`endif
    end else begin
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
      bit_cnt_q    <= (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
      case (rx_state_q)
        RX_IDLE: begin
          bit_cnt_q <= '0;
          if (rx_fall) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (bit_cnt_q == BIT_HALF) begin
            // realign the timer to mid-bit; a high line here was only a glitch
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
`ifdef IMEM_LOADER_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef IMEM_LOADER_PARITY_EN
              rx_state_q <= RX_PAR;
`else
              rx_state_q <= RX_STOP;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_PARITY_EN
        RX_PAR: begin
          if (bit_cnt_q == BIT_LAST) begin
            // even parity: data bits xor parity bit must be zero
            par_bad_q  <= (^shift_q) ^ rx_sync_q;
            rx_err_q   <= (^shift_q) ^ rx_sync_q;
            rx_state_q <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (bit_cnt_q == BIT_LAST) begin
            if (rx_sync_q) begin
`ifdef IMEM_LOADER_PARITY_EN
              byte_valid_q <= ~par_bad_q;
`else
              byte_valid_q <= 1'b1;
`endif
              rx_state_q   <= RX_IDLE;
            end else begin
              rx_err_q   <= 1'b1;
              rx_state_q <= RX_WAIT_HI;
            end
          end
        end
        RX_WAIT_HI: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Image loader: word count, then words assembled LSB byte first
  ld_state_e         ld_state_q;
  logic [15:0]       count_q;
  logic [15:0]       word_idx_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       asm_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;
  logic              in_range;

  assign in_range = (word_idx_q >> ADDR_W) == 16'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_q <= LD_CNT_LO;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (rx_err_q && ld_state_q != LD_DONE) err_q <= 1'b1;
      case (ld_state_q)
        LD_CNT_LO: begin
          if (byte_valid_q) begin
            count_q[7:0] <= shift_q;
            ld_state_q   <= LD_CNT_HI;
          end
        end
        LD_CNT_HI: begin
          if (byte_valid_q) begin
            count_q[15:8] <= shift_q;
            if ({shift_q, count_q[7:0]} == 16'd0) begin
              ld_state_q <= LD_DONE;
              done_q     <= 1'b1;
              hold_q     <= 1'b0;
            end else begin
              ld_state_q <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (byte_valid_q) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q != 2'd3) begin
              asm_q[{byte_idx_q, 3'b000} +: 8] <= shift_q;
            end else begin
              word_idx_q <= word_idx_q + 16'd1;
              if (in_range) begin
                we_q    <= 1'b1;
                addr_q  <= ADDR_W'(word_idx_q);
                wdata_q <= {shift_q, asm_q};
              end else begin
                err_q <= 1'b1;
              end
              // done follows one cycle later from LD_DONE, after the final strobe
              if (word_idx_q + 16'd1 == count_q) ld_state_q <= LD_DONE;
            end
          end
        end
        LD_DONE: begin
          done_q <= 1'b1;
          hold_q <= 1'b0;
        end
        default: ld_state_q <= LD_CNT_LO;
      endcase
    end
  end

  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;
  assign cpu_hold        = hold_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Testbench for imem_uart_loader: directed UART images, queue-based write scoreboard.
`timescale 1ns/1ps
module tb_imem_uart_loader;

  localparam int unsigned CPB = 16;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx = 1'b1;
  logic rx_o = 1'b1;
  logic cpu_hold, done, err;
  logic cpu_hold_o, done_o, err_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_we_cyc = -100;
  int done_rise_cyc = -100;
  logic done_prev = 1'b0;

  wr_t exp_q[$];
  wr_t exp_o_q[$];
  logic [7:0] img[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  imem_uart_loader_if #(.ADDR_W(6)) bus ();
  imem_uart_loader_if #(.ADDR_W(2)) bus_o ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .rx(rx), .imem(bus),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut_ovf (
    .clk(clk), .rst(rst), .rx(rx_o), .imem(bus_o),
    .cpu_hold(cpu_hold_o), .done(done_o), .err(err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // write monitors: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    wr_t e;
    if (rst && bus.imem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h with no write expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", bus.imem_wdata, e.data);
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
    done_prev = done;
  end

  always @(negedge clk) begin
    wr_t e;
    if (rst && bus_o.imem_we === 1'b1) begin
      if (exp_o_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write_ovf: addr 0x%0h data 0x%08h with no write expected",
                 bus_o.imem_addr, bus_o.imem_wdata);
      end else begin
        e = exp_o_q.pop_front();
        check("wr_addr_ovf", 32'(bus_o.imem_addr), 32'(e.addr));
        check("wr_data_ovf", bus_o.imem_wdata, e.data);
      end
    end
  end

  task automatic push_exp(input bit sel, input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (sel) exp_o_q.push_back(e);
    else exp_q.push_back(e);
  endtask

  task automatic drive(input bit sel, input logic v, input int cycles);
    if (sel) rx_o = v;
    else rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit bad_stop);
    drive(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(sel, b[i], CPB);
`ifdef IMEM_LOADER_PARITY_EN
    drive(sel, ^b, CPB);
`endif
    if (bad_stop) begin
      drive(sel, 1'b0, 40);
      drive(sel, 1'b1, 2 * CPB);
    end else begin
      drive(sel, 1'b1, CPB);
    end
  endtask

`ifdef IMEM_LOADER_PARITY_EN
  task automatic send_bad_parity(input bit sel, input logic [7:0] b);
    drive(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(sel, b[i], CPB);
    drive(sel, ~(^b), CPB);
    drive(sel, 1'b1, CPB);
  endtask
`endif

  task automatic send_seq(input bit sel, input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(sel, bytes[i], 1'b0);
  endtask

  task automatic wait_done(input bit sel, input int budget, input string name);
    int k;
    k = 0;
    while (((sel ? done_o : done) !== 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(sel ? done_o : done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    32'(bus.imem_we), 32'd0);
    check({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_hold"},  32'(cpu_hold), 32'd1);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    rx_o = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_img1();
    push_exp(1'b0, 16'd0, 32'h0050_0093);
    push_exp(1'b0, 16'd1, 32'h00A0_0113);
  endtask

  task automatic finish_img1(input string tag, input logic [31:0] exp_err);
    wait_done(1'b0, 40, {tag, "_done"});
    check({tag, "_done_timing"}, 32'(done_rise_cyc), 32'(last_we_cyc + 1));
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(err), exp_err);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // normal two-word image
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    expect_img1();
    send_seq(1'b0, img);
    finish_img1("normal", 32'd0);

    // empty image; traffic after done is ignored
    do_reset();
    img = '{8'h00, 8'h00};
    send_seq(1'b0, img);
    wait_done(1'b0, 40, "empty_done");
    check("empty_hold", 32'(cpu_hold), 32'd0);
    check("empty_err", 32'(err), 32'd0);
    img = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(1'b0, img);
    check("after_done_done", 32'(done), 32'd1);
    check("after_done_addr", 32'(bus.imem_addr), 32'd0);

    // start-bit glitch, then a normal image
    do_reset();
    drive(1'b0, 1'b0, 5);
    drive(1'b0, 1'b1, 3 * CPB);
    check("glitch_err", 32'(err), 32'd0);
    check("glitch_done", 32'(done), 32'd0);
    check("glitch_hold", 32'(cpu_hold), 32'd1);
    check("glitch_wdata", bus.imem_wdata, 32'd0);
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    expect_img1();
    send_seq(1'b0, img);
    finish_img1("glitch", 32'd0);

    // framing error, then a normal image
    do_reset();
    send_byte(1'b0, 8'h02, 1'b1);
    check("frame_err", 32'(err), 32'd1);
    check("frame_done", 32'(done), 32'd0);
    expect_img1();
    send_seq(1'b0, img);
    finish_img1("frame", 32'd1);

    // address overflow on the ADDR_W = 2 instance
    do_reset();
    img = '{8'h05, 8'h00,
            8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
            8'h33, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44,
            8'h55, 8'h55, 8'h55, 8'h55};
    push_exp(1'b1, 16'd0, 32'h1111_1111);
    push_exp(1'b1, 16'd1, 32'h2222_2222);
    push_exp(1'b1, 16'd2, 32'h3333_3333);
    push_exp(1'b1, 16'd3, 32'h4444_4444);
    send_seq(1'b1, img);
    wait_done(1'b1, 40, "ovf_done");
    check("ovf_err", 32'(err_o), 32'd1);
    check("ovf_hold", 32'(cpu_hold_o), 32'd0);
    check("ovf_pending", 32'(exp_o_q.size()), 32'd0);

    // reset in the middle of the first word (err already set by a framing error)
    do_reset();
    send_byte(1'b0, 8'h02, 1'b1);
    img = '{8'h02, 8'h00, 8'h93, 8'h00};
    send_seq(1'b0, img);
    check("midrst_pre_err", 32'(err), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    img = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    expect_img1();
    send_seq(1'b0, img);
    finish_img1("midrst", 32'd0);

`ifdef IMEM_LOADER_PARITY_EN
    // byte with wrong parity is skipped and flags err
    do_reset();
    img = '{8'h02, 8'h00};
    send_seq(1'b0, img);
    send_bad_parity(1'b0, 8'h93);
    check("par_err", 32'(err), 32'd1);
    img = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    expect_img1();
    send_seq(1'b0, img);
    finish_img1("par", 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
